// File: rtl/riscv_hpm_counters.sv
// Hardware performance counters: N_COUNTERS event-selectable counters with CSR access and overflow tracking.
// Define HPM_OVF_IRQ_EN to build the overflow interrupt (IE register and registered irq_o).
module riscv_hpm_counters #(
    parameter int N_COUNTERS = 4,
    parameter int CNT_WIDTH  = 64,
    parameter int N_EVENTS   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                csr_access_i,
    input  logic [11:0]         csr_addr_i,
    input  logic [31:0]         csr_wdata_i,
    input  logic [1:0]          csr_op_i,
    output logic [31:0]         csr_rdata_o,
    output logic                csr_hit_o,
    input  logic [N_EVENTS-1:0] events_i,
    output logic                irq_o
);
    localparam logic [1:0] CSR_OP_NONE  = 2'd0;
    localparam logic [1:0] CSR_OP_WRITE = 2'd1;
    localparam logic [1:0] CSR_OP_SET   = 2'd2;
    localparam logic [1:0] CSR_OP_CLEAR = 2'd3;
    localparam logic [4:0] NC           = 5'(N_COUNTERS);

    function automatic logic [31:0] csr_apply(input logic [1:0] op, input logic [31:0] cur,
                                              input logic [31:0] wd);
        case (op)
            CSR_OP_WRITE: return wd;
            CSR_OP_SET:   return cur | wd;
            CSR_OP_CLEAR: return cur & ~wd;
            default:      return cur;
        endcase
    endfunction

    logic [N_COUNTERS-1:0][CNT_WIDTH-1:0] cnt, cnt_nv;
    logic [N_COUNTERS-1:0][4:0]           sel;
    logic [N_COUNTERS-1:0]                inc, inc_q, ovf, ovf_set, ovf_clr, ie;
    logic [2:0]                           ctrl;
    logic [31:0]                          ev_ext, wr_val, lo_rd, hi_rd;
    logic [63:0]                          r64, w64;
    logic [4:0]                           sel_rd;
    logic [3:0]                           idx;
    logic idx_ok, wr_op, gen, sat, frz;
    logic lo_hit, hi_hit, sel_hit, ctrl_hit, ovf_hit, ie_hit;

    assign gen    = ctrl[0];
    assign sat    = ctrl[1];
    assign frz    = ctrl[2];
    assign ev_ext = 32'(events_i);

    assign idx      = csr_addr_i[3:0];
    assign idx_ok   = {1'b0, idx} < NC;
    assign wr_op    = csr_op_i != CSR_OP_NONE;
    assign lo_hit   = csr_access_i && csr_addr_i[11:4] == 8'h78 && idx_ok;
    assign hi_hit   = csr_access_i && csr_addr_i[11:4] == 8'h79 && idx_ok;
    assign sel_hit  = csr_access_i && csr_addr_i[11:4] == 8'h7A && idx_ok;
    assign ctrl_hit = csr_access_i && csr_addr_i == 12'h7C8;
    assign ovf_hit  = csr_access_i && csr_addr_i == 12'h7C9;
    assign ie_hit   = csr_access_i && csr_addr_i == 12'h7CA;
    assign csr_hit_o = lo_hit | hi_hit | sel_hit | ctrl_hit | ovf_hit | ie_hit;

    always_comb begin
        lo_rd  = '0;
        hi_rd  = '0;
        sel_rd = '0;
        r64    = '0;
        for (int k = 0; k < N_COUNTERS; k++) begin
            if (idx == 4'(k)) begin
                r64    = 64'(cnt[k]);
                lo_rd  = r64[31:0];
                hi_rd  = r64[63:32];
                sel_rd = sel[k];
            end
        end
        csr_rdata_o = '0;
        if (lo_hit)        csr_rdata_o = lo_rd;
        else if (hi_hit)   csr_rdata_o = hi_rd;
        else if (sel_hit)  csr_rdata_o = 32'(sel_rd);
        else if (ctrl_hit) csr_rdata_o = 32'(ctrl);
        else if (ovf_hit)  csr_rdata_o = 32'(ovf);
        else if (ie_hit)   csr_rdata_o = 32'(ie);
    end

    // The read value is exactly the implemented bits, so read-modify-write never touches the rest.
    assign wr_val  = csr_apply(csr_op_i, csr_rdata_o, csr_wdata_i);
    assign ovf_clr = (ovf_hit && (csr_op_i == CSR_OP_WRITE || csr_op_i == CSR_OP_SET))
                     ? csr_wdata_i[N_COUNTERS-1:0] : '0;

    always_comb begin
        cnt_nv  = cnt;
        ovf_set = '0;
        inc     = '0;
        w64     = '0;
        for (int k = 0; k < N_COUNTERS; k++) begin
            inc[k] = ev_ext[sel[k]] & gen & ~(frz & |ovf);
            w64    = 64'(cnt[k]);
            // A software write to either half wins; the pending increment is dropped.
            if (lo_hit && wr_op && idx == 4'(k)) begin
                w64[31:0] = wr_val;
                cnt_nv[k] = CNT_WIDTH'(w64);
            end else if (hi_hit && wr_op && idx == 4'(k) && CNT_WIDTH > 32) begin
                w64[63:32] = wr_val;
                cnt_nv[k]  = CNT_WIDTH'(w64);
            end else if (inc_q[k]) begin
                if (&cnt[k]) begin
                    if (!sat) begin
                        cnt_nv[k]  = '0;
                        ovf_set[k] = 1'b1;
                    end
                end else begin
                    cnt_nv[k] = cnt[k] + CNT_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            sel   <= '0;
            inc_q <= '0;
            ovf   <= '0;
            ctrl  <= 3'b001;
        end else begin
            cnt   <= cnt_nv;
            inc_q <= inc;
            ovf   <= (ovf & ~ovf_clr) | ovf_set;
            if (ctrl_hit && wr_op) ctrl <= wr_val[2:0];
            for (int k = 0; k < N_COUNTERS; k++)
                if (sel_hit && wr_op && idx == 4'(k)) sel[k] <= wr_val[4:0];
        end
    end

`ifdef HPM_OVF_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ie    <= '0;
            irq_q <= 1'b0;
        end else begin
            if (ie_hit && wr_op) ie <= wr_val[N_COUNTERS-1:0];
            irq_q <= |(ovf & ie);
        end
    end
    assign irq_o = irq_q;
`else
    assign ie    = '0;
    assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_riscv_hpm_counters.sv
// Scoreboard bench for riscv_hpm_counters: directed CSR/event stimulus, expectations queued, checked by a monitor.
module tb_riscv_hpm_counters;
    localparam logic [11:0] A_LO = 12'h780, A_HI = 12'h790, A_SEL = 12'h7A0;
    localparam logic [11:0] A_CTRL = 12'h7C8, A_OVF = 12'h7C9, A_IE = 12'h7CA;
    localparam logic [1:0] OP_NONE = 2'd0, OP_WRITE = 2'd1, OP_SET = 2'd2, OP_CLEAR = 2'd3;
`ifdef HPM_OVF_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif
    localparam logic [31:0] IE_EXP  = IRQ_EN ? 32'h2 : 32'h0;
    localparam logic [31:0] IRQ_EXP = IRQ_EN ? 32'h1 : 32'h0;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        csr_access = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_wdata = '0;
    logic [1:0]  csr_op = '0;
    logic [31:0] csr_rdata;
    logic        csr_hit, irq;
    logic [15:0] events = '0;

    riscv_hpm_counters dut (
        .clk(clk), .rst_n(rst_n), .csr_access_i(csr_access), .csr_addr_i(csr_addr),
        .csr_wdata_i(csr_wdata), .csr_op_i(csr_op), .csr_rdata_o(csr_rdata),
        .csr_hit_o(csr_hit), .events_i(events), .irq_o(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          is_irq;
        logic        hit;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int checks = 0, failures = 0;
    logic rd_stb = 1'b0, irq_stb = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        csr_access = 1'b1; csr_addr = a; csr_op = op; csr_wdata = d;
        tick();
        csr_access = 1'b0; csr_op = OP_NONE; csr_wdata = '0;
    endtask

    task automatic csr_rd(input string nm, input logic [11:0] a, input logic [31:0] exp,
                          input logic exp_hit = 1'b1);
        csr_access = 1'b1; csr_addr = a; csr_op = OP_NONE; csr_wdata = '0;
        sb.push_back('{name: nm, is_irq: 1'b0, hit: exp_hit, data: exp});
        rd_stb = 1'b1;
        tick();
        csr_access = 1'b0; rd_stb = 1'b0;
    endtask

    task automatic chk_irq(input string nm, input logic [31:0] exp);
        sb.push_back('{name: nm, is_irq: 1'b1, hit: 1'b0, data: exp});
        irq_stb = 1'b1;
        tick();
        irq_stb = 1'b0;
    endtask

    task automatic pulse(input int i);
        events = '0; events[i] = 1'b1;
        tick();
        events = '0;
    endtask

    task automatic preload(input int k, input logic [31:0] lo, input logic [31:0] hi);
        csr_wr(A_LO + 12'(k), OP_WRITE, lo);
        csr_wr(A_HI + 12'(k), OP_WRITE, hi);
    endtask

    always @(negedge clk) begin
        if (rd_stb || irq_stb) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL scoreboard_underflow: got empty queue expected an entry");
            end else begin
                e = sb.pop_front();
                if (e.is_irq) cmp(e.name, {31'b0, irq}, e.data);
                else begin
                    cmp({e.name, "_hit"}, {31'b0, csr_hit}, {31'b0, e.hit});
                    cmp(e.name, csr_rdata, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        cmp("reset_irq", {31'b0, irq}, 32'h0);
        cmp("reset_hit", {31'b0, csr_hit}, 32'h0);
        rst_n = 1'b1;
        tick();
        csr_rd("rst_ctrl", A_CTRL, 32'h1);
        csr_rd("rst_ovf", A_OVF, 32'h0);
        csr_rd("rst_ie", A_IE, 32'h0);
        csr_rd("rst_sel0", A_SEL, 32'h0);
        csr_rd("rst_lo0", A_LO, 32'h0);
        csr_rd("rst_hi3", A_HI + 12'd3, 32'h0);
        csr_rd("unmapped_lo4", A_LO + 12'd4, 32'h0, 1'b0);
        csr_rd("unmapped_7cb", 12'h7CB, 32'h0, 1'b0);

        // basic count: 5 pulses on event 3, visible two cycles after the last
        csr_wr(A_SEL, OP_WRITE, 32'd3);
        for (int i = 0; i < 5; i++) begin
            pulse(3);
            if (i < 4) tick();
        end
        csr_rd("basic_t1", A_LO, 32'd4);
        csr_rd("basic_t2", A_LO, 32'd5);
        csr_rd("basic_lo1", A_LO + 12'd1, 32'h0);
        csr_rd("basic_lo2", A_LO + 12'd2, 32'h0);
        csr_rd("basic_hi0", A_HI, 32'h0);

        csr_wr(A_CTRL, OP_SET, 32'h2);
        csr_rd("ctrl_set", A_CTRL, 32'h3);
        csr_wr(A_CTRL, OP_CLEAR, 32'h2);
        csr_rd("ctrl_clear", A_CTRL, 32'h1);

        // wrap and interrupt
        csr_wr(A_SEL + 12'd1, OP_WRITE, 32'd5);
        preload(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        csr_wr(A_IE, OP_WRITE, 32'h2);
        csr_rd("ie_rd", A_IE, IE_EXP);
        csr_rd("wrap_pre_lo1", A_LO + 12'd1, 32'hFFFF_FFFF);
        pulse(5);
        csr_rd("wrap_ovf_t1", A_OVF, 32'h0);
        chk_irq("wrap_irq_t2", 32'h0);
        chk_irq("wrap_irq_t3", IRQ_EXP);
        csr_rd("wrap_ovf", A_OVF, 32'h2);
        csr_rd("wrap_lo1", A_LO + 12'd1, 32'h0);
        csr_rd("wrap_hi1", A_HI + 12'd1, 32'h0);
        csr_wr(A_OVF, OP_CLEAR, 32'h2);
        csr_rd("ovf_clear_noop", A_OVF, 32'h2);
        csr_wr(A_OVF, OP_WRITE, 32'h2);
        csr_rd("ovf_w1c", A_OVF, 32'h0);
        chk_irq("irq_dropped", 32'h0);

        // saturate
        csr_wr(A_CTRL, OP_SET, 32'h2);
        preload(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            pulse(5);
            tick();
        end
        tick();
        csr_rd("sat_lo1", A_LO + 12'd1, 32'hFFFF_FFFF);
        csr_rd("sat_hi1", A_HI + 12'd1, 32'hFFFF_FFFF);
        csr_rd("sat_ovf", A_OVF, 32'h0);
        csr_wr(A_CTRL, OP_CLEAR, 32'h2);

        // write collides with increment landing on the same edge
        csr_wr(A_HI, OP_WRITE, 32'hA);
        pulse(3);
        csr_wr(A_LO, OP_WRITE, 32'h10);
        tick();
        csr_rd("collide_lo0", A_LO, 32'h10);
        csr_rd("collide_hi0", A_HI, 32'hA);

        // freeze while overflow pending, resume after W1C
        csr_wr(A_CTRL, OP_SET, 32'h4);
        csr_wr(A_SEL + 12'd2, OP_WRITE, 32'd7);
        preload(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        pulse(7);
        tick(); tick();
        csr_rd("frz_ovf", A_OVF, 32'h4);
        csr_rd("frz_lo2", A_LO + 12'd2, 32'h0);
        pulse(3);
        pulse(7);
        tick(); tick();
        csr_rd("frz_hold_lo0", A_LO, 32'h10);
        csr_rd("frz_hold_lo2", A_LO + 12'd2, 32'h0);
        csr_wr(A_OVF, OP_WRITE, 32'h4);
        csr_rd("frz_ovf_clr", A_OVF, 32'h0);
        pulse(3);
        tick();
        csr_rd("frz_resume_lo0", A_LO, 32'h11);
        csr_wr(A_CTRL, OP_CLEAR, 32'h4);

        // select boundaries and simultaneous increments
        csr_wr(A_SEL + 12'd3, OP_WRITE, 32'hFFFF_FFFF);
        csr_rd("sel_bits", A_SEL + 12'd3, 32'h1F);
        csr_wr(A_SEL + 12'd3, OP_WRITE, 32'd16);
        csr_rd("sel_16", A_SEL + 12'd3, 32'h10);
        csr_wr(A_SEL + 12'd1, OP_WRITE, 32'd3);
        csr_wr(A_SEL + 12'd2, OP_WRITE, 32'd31);
        preload(1, 32'h0, 32'h0);
        events = '1;
        tick();
        events = '0;
        tick();
        csr_rd("multi_lo0", A_LO, 32'h12);
        csr_rd("multi_lo1", A_LO + 12'd1, 32'h1);
        csr_rd("multi_lo2", A_LO + 12'd2, 32'h0);
        csr_rd("multi_lo3", A_LO + 12'd3, 32'h0);
        csr_rd("multi_hi1", A_HI + 12'd1, 32'h0);

        // reset mid-count with an increment pending
        events = 16'h0008;
        tick();
        events = 16'h0010;
        #2 rst_n = 1'b0;
        #1;
        cmp("midrst_irq", {31'b0, irq}, 32'h0);
        cmp("midrst_hit", {31'b0, csr_hit}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            events = ~events;
            tick();
        end
        events = '0;
        rst_n = 1'b1;
        tick();
        csr_rd("midrst_lo0", A_LO, 32'h0);
        csr_rd("midrst_hi0", A_HI, 32'h0);
        csr_rd("midrst_sel0", A_SEL, 32'h0);
        csr_rd("midrst_ctrl", A_CTRL, 32'h1);
        csr_rd("midrst_ovf", A_OVF, 32'h0);
        csr_rd("midrst_ie", A_IE, 32'h0);
        csr_wr(A_SEL, OP_WRITE, 32'd3);
        pulse(3);
        csr_rd("post_rst_t1", A_LO, 32'h0);
        csr_rd("post_rst_t2", A_LO, 32'h1);

        tick(); tick();
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/riscv_hpm_counters.md
RISCV_HPM_COUNTERS -- requirements
Module: riscv_hpm_counters

Interface
REQ-001 SHALL have parameter N_COUNTERS, default 4: number of counters, legal range 1..16.
REQ-002 SHALL have parameter CNT_WIDTH, default 64: counter width, legal range 32..64.
REQ-003 SHALL have parameter N_EVENTS, default 16: number of event inputs, legal range 1..32.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port csr_access_i, input, 1 bit: a CSR access is present this cycle.
REQ-007 SHALL have port csr_addr_i, input, 12 bits: CSR address.
REQ-008 SHALL have port csr_wdata_i, input, 32 bits: write operand.
REQ-009 SHALL have port csr_op_i, input, 2 bits: operation, encoded as CSR_OP_NONE/WRITE/SET/CLEAR.
REQ-010 SHALL have port csr_rdata_o, output, 32 bits: read data.
REQ-011 SHALL have port csr_hit_o, output, 1 bit: address decodes to this block.
REQ-012 SHALL have port events_i, input, N_EVENTS bits: single-cycle event pulses.
REQ-013 SHALL have port irq_o, output, 1 bit: overflow interrupt.

Function
REQ-014 Address map: CNTLO[k]=0x780+k (bits 31:0); CNTHI[k]=0x790+k (bits CNT_WIDTH-1:32, zero-extended; read-zero/write-ignored when CNT_WIDTH=32); SEL[k]=0x7A0+k (bits 4:0 event index); CTRL=0x7C8; OVF=0x7C9; IE=0x7CA.
REQ-015 csr_hit_o SHALL be csr_access_i AND address in the map with k<N_COUNTERS; otherwise csr_rdata_o=0 and there is no state change.
REQ-016 CTRL bit0 GEN (global enable), bit1 SAT (saturate), bit2 FRZ (freeze all counters while any OVF bit is set).
REQ-017 Operations on a hit: WRITE stores wdata; SET stores wdata|current; CLEAR stores ~wdata&current; NONE leaves state unchanged. Operations SHALL act only on the bits the register implements.
REQ-018 Inc request inc[k] = events_i[SEL[k]] & GEN & ~(FRZ & |OVF); a SEL value >= N_EVENTS SHALL never increment.
REQ-019 inc SHALL be registered (inc_q); the counter updates on the edge after inc_q is set, so an event at cycle t is visible in a read at cycle t+2.
REQ-020 Increment at all-ones: SAT=1 holds all-ones with OVF[k] unchanged; SAT=0 wraps to 0 and sets OVF[k].
REQ-021 A CSR write to CNTLO[k]/CNTHI[k] SHALL take priority over a same-cycle increment of counter k; the increment is dropped and the other half is preserved.
REQ-022 OVF is write-1-to-clear for WRITE and SET (set bits clear); CLEAR has no effect; a same-cycle hardware set wins over software clear.
REQ-023 Reads SHALL be combinational from current register state, with no side effects.
REQ-024 Counters SHALL be independent; any number may increment in the same cycle.

Reset
REQ-025 On rst_n low: counters=0, SEL=0, inc_q=0, OVF=0, IE=0, CTRL=3'b001, irq_o=0, csr_hit_o=0.
REQ-026 Reset asserted mid-count SHALL discard any pending inc_q without incrementing.

Configuration
REQ-027 Macro HPM_OVF_IRQ_EN defined: irq_o = |(OVF & IE), registered (one cycle after OVF sets), and IE is read/write.
REQ-028 HPM_OVF_IRQ_EN undefined: irq_o tied 0, IE reads 0 and ignores writes; OVF and FRZ behaviour are unchanged.

Verification
REQ-029 Scenario, basic count: SEL[0]=3, GEN=1, pulse events_i[3] 5 times -> CNTLO[0]=5 at 2 cycles after the last pulse; other counters=0.
REQ-030 Scenario, wrap: SAT=0, write CNTLO[1]=0xFFFFFFFF and CNTHI[1]=0xFFFFFFFF (CNT_WIDTH=64), one event -> counter=0, OVF=0x2; with IE=0x2 and HPM_OVF_IRQ_EN, irq_o=1 one cycle after OVF sets.
REQ-031 Scenario, saturate: SAT=1, same preload, 3 events -> counter stays all-ones, OVF=0.
REQ-032 Scenario, write-vs-increment collision: inc_q[0]=1 in the same cycle as WRITE CNTLO[0]=0x10 -> CNTLO[0]=0x10, not 0x11.
REQ-033 Scenario, freeze and W1C: FRZ=1, counter 2 overflows -> all counters hold; WRITE OVF=0x4 -> OVF=0 and counting resumes.
REQ-034 Scenario, reset mid-count: assert rst_n low while events_i toggles -> every register reads its REQ-025 value; after release, first count lands at t+2.
